soft_depuncture: RTL
====================

SOFT_DEPUNCTURE -- requirements
Module: soft_depuncture

Interface
REQ-001 SHALL: clk_h  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: ival  input  1  ibit valid; one soft bit per cycle, bursty, no backpressure.
REQ-004 SHALL: ibit  input  5  signed LLR in transmitted order from the serializer stage.
REQ-005 SHALL: isof  input  1  start of frame; meaningful only with ival=1.
REQ-006 SHALL: code_rate  input  2  code rate: 0=1/2, 1=2/3, 2=3/4, 3=5/6; sampled only on ival&isof.
REQ-007 SHALL: oval  output  1  ox/oy/oerase/osof valid, single-cycle pulse per mother-code pair.
REQ-008 SHALL: ox, oy  output  5 each  signed mother-code LLR pair (X, Y) for the Viterbi decoder.
REQ-009 SHALL: oerase  output  2  bit1: ox is an inserted erasure; bit0: oy is an inserted erasure.
REQ-010 SHALL: osof  output  1  marks the first pair of a frame.

Function
REQ-011 SHALL: puncture patterns (X row / Y row, period P): 1/2 X=1 Y=1 (P=1); 2/3 X=10 Y=11 (P=2); 3/4 X=101 Y=110 (P=3); 5/6 X=10101 Y=11010 (P=5).
REQ-012 SHALL: transmitted order within a position is X then Y, skipping punctured entries (e.g. 3/4 stream X1 Y1 Y2 X3).
REQ-013 SHALL: track position p (0..P-1) and sub-phase (expect X / expect Y); every ival consumes exactly one transmitted entry.
REQ-014 SHALL: a punctured entry is filled with LLR 0 and its oerase bit is set.
REQ-015 SHALL: the pair is emitted once the last transmitted entry of position p arrives: registered outputs, oval high the cycle after that ival (latency 1); p then wraps (P-1 -> 0).
REQ-016 SHALL: at most one oval per ival; ival gaps of any length do not alter state.
REQ-017 SHALL: ival&isof latches code_rate into an active-rate register, forces p=0 and sub-phase X, and the ibit in that cycle is the first entry of the frame.
REQ-018 SHALL: ival&isof arriving mid-pair discards the partial pair silently, with no oval for it.
REQ-019 SHALL: osof=1 with the first oval following an isof; otherwise 0.
REQ-020 SHALL: a code_rate change without isof has no effect until the next isof.
REQ-021 SHALL: when oval=0, ox, oy, oerase and osof are 0.
REQ-022 SHALL: ibit values pass through unmodified; no saturation or scaling.

Reset
REQ-023 SHALL: rst_n=0 asynchronously clears oval, ox, oy, oerase and osof to 0, sets p=0, sets sub-phase X, and sets the active rate to 1/2.
REQ-024 SHALL: reset mid-frame discards any partial pair; the first ival after release is treated as an X entry at p=0 under rate 1/2 unless accompanied by isof.

Configuration
REQ-025 SHALL: macro SOFT_DEPUNCTURE_RATE56_EN defined -> rate 5/6 supported as in REQ-011.
REQ-026 SHALL: macro SOFT_DEPUNCTURE_RATE56_EN undefined -> code_rate=3 latches as rate 1/2 and no 5/6 pattern logic is built; rates 0-2 are unchanged.

Verification
REQ-027 SHALL: rate 1/2: isof with stream 5,-3,7,1 -> two ovals: (5,-3, erase 00, osof 1) then (7,1, erase 00).
REQ-028 SHALL: rate 3/4: isof with stream 4,-2,6,-8 -> (4,-2,00), (0,6,10), (-8,0,01); then the pattern wraps to p=0.
REQ-029 SHALL: rate 2/3: stream with ival gaps of 0-5 cycles -> same pair sequence as gap-free input; each oval exactly 1 cycle after the completing ival.
REQ-030 SHALL: mid-pair isof: rate 1/2, X=3 received, then isof with rate 3/4 and 9 -> no pair containing 3; the next pair's ox is 9 and osof=1.
REQ-031 SHALL: rst_n pulse asserted between a position's X and Y -> outputs 0 immediately; the next two ivals produce one rate 1/2 pair.
REQ-032 SHALL: rate 5/6 with the macro defined, 6 entries a..f -> (a,b,00), (0,c,10), (d,0,01), (0,e,10), (f,0,01); with the macro undefined -> three rate 1/2 pairs.

Source files
------------

// File: rtl/soft_depuncture.sv
// rtl/soft_depuncture.sv - soft-decision depuncturer producing mother-code (X,Y) LLR pairs
// Optional feature macro: SOFT_DEPUNCTURE_RATE56_EN (adds rate 5/6 pattern support)
module soft_depuncture (
  input  logic       clk_h,
  input  logic       rst_n,
  input  logic       ival,
  input  logic [4:0] ibit,
  input  logic       isof,
  input  logic [1:0] code_rate,
  output logic       oval,
  output logic [4:0] ox,
  output logic [4:0] oy,
  output logic [1:0] oerase,
  output logic       osof
);

  localparam logic [1:0] RATE_12 = 2'd0;
  localparam logic [1:0] RATE_23 = 2'd1;
  localparam logic [1:0] RATE_34 = 2'd2;
  localparam logic [1:0] RATE_56 = 2'd3;

  typedef enum logic {PH_X, PH_Y} phase_t;

  logic [1:0] rate_q, rate_d;
  logic [2:0] pos_q, pos_d;
  phase_t     phase_q, phase_d;
  logic [4:0] xhold_q, xhold_d;
  logic       sofpend_q, sofpend_d;
  logic       oval_q, oval_d;
  logic [4:0] ox_q, ox_d;
  logic [4:0] oy_q, oy_d;
  logic [1:0] oerase_q, oerase_d;
  logic       osof_q, osof_d;

  logic [1:0] rate_in;
  logic [1:0] rate_use;
  logic [2:0] pos_use;
  phase_t     phase_use;
  logic       pend_use;
  logic [2:0] pos_last;
  logic       x_kept;
  logic       y_kept;

  // Map the sampled code_rate onto a rate this build supports
  always_comb begin
`ifdef SOFT_DEPUNCTURE_RATE56_EN
    rate_in = code_rate;
`else
    rate_in = (code_rate == RATE_56) ? RATE_12 : code_rate;
`endif
  end

  // Context for the current entry: an isof restarts the frame at p=0, phase X
  always_comb begin
    rate_use  = rate_q;
    pos_use   = pos_q;
    phase_use = phase_q;
    pend_use  = sofpend_q;
    if (ival && isof) begin
      rate_use  = rate_in;
      pos_use   = 3'd0;
      phase_use = PH_X;
      pend_use  = 1'b1;
    end
  end

  // Puncture table: period end and which rows are transmitted at this position
  always_comb begin
    pos_last = 3'd0;
    x_kept   = 1'b1;
    y_kept   = 1'b1;
    case (rate_use)
      RATE_23: begin
        pos_last = 3'd1;
        x_kept   = (pos_use == 3'd0);
      end
      RATE_34: begin
        pos_last = 3'd2;
        x_kept   = (pos_use != 3'd1);
        y_kept   = (pos_use != 3'd2);
      end
`ifdef SOFT_DEPUNCTURE_RATE56_EN
      RATE_56: begin
        pos_last = 3'd4;
        x_kept   = (pos_use == 3'd0) || (pos_use == 3'd2) || (pos_use == 3'd4);
        y_kept   = (pos_use == 3'd0) || (pos_use == 3'd1) || (pos_use == 3'd3);
      end
`endif
      default: ;
    endcase
  end

  // Consume one transmitted entry per ival; emit the pair when its position completes
  always_comb begin
    rate_d    = rate_q;
    pos_d     = pos_q;
    phase_d   = phase_q;
    xhold_d   = xhold_q;
    sofpend_d = sofpend_q;
    oval_d    = 1'b0;
    ox_d      = 5'd0;
    oy_d      = 5'd0;
    oerase_d  = 2'b00;
    osof_d    = 1'b0;
    if (ival) begin
      rate_d    = rate_use;
      pos_d     = pos_use;
      phase_d   = phase_use;
      sofpend_d = pend_use;
      if (phase_use == PH_Y) begin
        oval_d = 1'b1;
        ox_d   = xhold_q;
        oy_d   = ibit;
      end else if (x_kept && y_kept) begin
        xhold_d = ibit;
        phase_d = PH_Y;
      end else if (x_kept) begin
        oval_d   = 1'b1;
        ox_d     = ibit;
        oerase_d = 2'b01;
      end else begin
        oval_d   = 1'b1;
        oy_d     = ibit;
        oerase_d = 2'b10;
      end
      if (oval_d) begin
        osof_d    = pend_use;
        sofpend_d = 1'b0;
        phase_d   = PH_X;
        pos_d     = (pos_use == pos_last) ? 3'd0 : pos_use + 3'd1;
      end
    end
  end

  // State and registered outputs; reset returns to rate 1/2, p=0, phase X
  always_ff @(posedge clk_h or negedge rst_n) begin
    if (!rst_n) begin
      rate_q    <= RATE_12;
      pos_q     <= 3'd0;
      phase_q   <= PH_X;
      xhold_q   <= 5'd0;
      sofpend_q <= 1'b0;
      oval_q    <= 1'b0;
      ox_q      <= 5'd0;
      oy_q      <= 5'd0;
      oerase_q  <= 2'b00;
      osof_q    <= 1'b0;
    end else begin
      rate_q    <= rate_d;
      pos_q     <= pos_d;
      phase_q   <= phase_d;
      xhold_q   <= xhold_d;
      sofpend_q <= sofpend_d;
      oval_q    <= oval_d;
      ox_q      <= ox_d;
      oy_q      <= oy_d;
      oerase_q  <= oerase_d;
      osof_q    <= osof_d;
    end
  end

  assign oval   = oval_q;
  assign ox     = ox_q;
  assign oy     = oy_q;
  assign oerase = oerase_q;
  assign osof   = osof_q;

endmodule
